// File: rtl/fmap_stream_tx.sv
// Streams a feature map out of a synchronous-read memory, channel fastest, then x, then y,
// on a valid/ready interface with coordinate tags, zero flag and last marker.
module fmap_stream_tx #(
   parameter int DATA_WIDTH         = 16,
   parameter int FEATURE_MAP_WIDTH  = 128,
   parameter int FEATURE_MAP_HEIGHT = 128,
   parameter int INPUT_NB_CHANNELS  = 2,
   parameter int ADDR_WIDTH         = 16,
   localparam int XW = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1,
   localparam int YW = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
   localparam int CW = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1
) (
   input  logic                  clk,
   input  logic                  rst_in,
   input  logic                  start,
   output logic                  running,
   output logic                  done,
   output logic                  mem_re,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   input  logic                  data_ready,
   output logic                  zero_flag,
   output logic                  last,
   output logic [XW-1:0]         out_x,
   output logic [YW-1:0]         out_y,
   output logic [CW-1:0]         out_ch
);

   localparam longint TOTAL = longint'(FEATURE_MAP_WIDTH) * longint'(FEATURE_MAP_HEIGHT)
                              * longint'(INPUT_NB_CHANNELS);

   generate
      if (TOTAL > (longint'(1) << ADDR_WIDTH)) begin : g_size_check
         $error("fmap_stream_tx: feature map does not fit in ADDR_WIDTH address bits");
      end
   endgenerate

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL - 1);
   localparam logic [XW-1:0]         X_MAX     = XW'(FEATURE_MAP_WIDTH - 1);
   localparam logic [YW-1:0]         Y_MAX     = YW'(FEATURE_MAP_HEIGHT - 1);
   localparam logic [CW-1:0]         C_MAX     = CW'(INPUT_NB_CHANNELS - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [XW-1:0]         x;
      logic [YW-1:0]         y;
      logic [CW-1:0]         ch;
      logic                  last;
      logic                  zero;
   } entry_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [XW-1:0]         x_q, x_d;
   logic [YW-1:0]         y_q, y_d;
   logic [CW-1:0]         ch_q, ch_d;
   logic                  in_flight_q, in_flight_d;
   entry_t                flight_q, flight_d;
   entry_t                head_q, head_d;
   entry_t                tail_q, tail_d;
   logic [1:0]            count_q, count_d;
   logic                  done_q, done_d;

   logic   issue;
   logic   pop;
   entry_t push_e;

   always_comb begin
      pop    = (count_q != 2'd0) && data_ready;
      // Outstanding words (queued + in flight) minus this cycle's pop must leave room for one more.
      issue  = (state_q == S_ISSUE) &&
               ((3'(count_q) + 3'(in_flight_q)) < (3'd2 + 3'(pop)));
      push_e      = flight_q;
      push_e.data = mem_rdata;
      push_e.zero = (mem_rdata == '0);

      state_d     = state_q;
      addr_d      = addr_q;
      x_d         = x_q;
      y_d         = y_q;
      ch_d        = ch_q;
      flight_d    = flight_q;
      in_flight_d = issue;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ISSUE;
               addr_d  = '0;
               x_d     = '0;
               y_d     = '0;
               ch_d    = '0;
            end
         end
         S_ISSUE: begin
            if (issue) begin
               flight_d = '{data: '0, x: x_q, y: y_q, ch: ch_q,
                            last: (addr_q == LAST_ADDR), zero: 1'b0};
               addr_d   = addr_q + 1'b1;
               if (ch_q == C_MAX) begin
                  ch_d = '0;
                  if (x_q == X_MAX) begin
                     x_d = '0;
                     y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
                  end else begin
                     x_d = x_q + 1'b1;
                  end
               end else begin
                  ch_d = ch_q + 1'b1;
               end
               if (addr_q == LAST_ADDR) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pop && head_q.last) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Two-entry FIFO: head is the output register, tail only fills while the head is stalled.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case ({in_flight_q, pop})
         2'b10: begin
            if (count_q == 2'd0) head_d = push_e;
            else                 tail_d = push_e;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd1) begin
               head_d = push_e;
            end else begin
               head_d = tail_q;
               tail_d = push_e;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         x_q         <= '0;
         y_q         <= '0;
         ch_q        <= '0;
         in_flight_q <= 1'b0;
         flight_q    <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= 2'd0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         x_q         <= x_d;
         y_q         <= y_d;
         ch_q        <= ch_d;
         in_flight_q <= in_flight_d;
         flight_q    <= flight_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         done_q      <= done_d;
      end
   end

   assign running    = (state_q != S_IDLE);
   assign done       = done_q;
   assign mem_re     = issue;
   assign mem_addr   = addr_q;
   assign data_valid = (count_q != 2'd0);
   assign data_out   = head_q.data;
   assign zero_flag  = head_q.zero && data_valid;
   assign last       = head_q.last && data_valid;
   assign out_x      = head_q.x;
   assign out_y      = head_q.y;
   assign out_ch     = head_q.ch;

endmodule
